// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit framer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eth_pkg;

    // One state per frame field, plus idle and the inter-frame gap.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DST,
        ST_SRC,
        ST_TYPE,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_GAP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    // Register value left after running the CRC over data plus its own FCS.
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // One byte of the bit-reflected IEEE 802.3 CRC-32, LSB of the data first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] rpoly;
        logic [31:0] c;
        for (int i = 0; i < 32; i++) begin
            rpoly[i] = CRC_POLY[31-i];
        end
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ rpoly;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_crc.sv
// Byte-wide CRC-32 engine: running register, FCS is its complement.
// Latency: one cycle per byte; fcs reflects all bytes enabled so far.
// Backpressure: none; caller gates with en, restarts with init.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (reinitialises the CRC)
//   i_init         : reload CRC_INIT (has priority over i_en)
//   i_en, i_data   : absorb one byte
//   o_fcs          : complemented CRC, transmitted LSB byte first
module crc32_in8
    import eth_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_fcs
);

    logic [31:0] crc_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc_q <= CRC_INIT;
        end else if (i_init) begin
            crc_q <= CRC_INIT;
        end else if (i_en) begin
            crc_q <= crc32_next(crc_q, i_data);
        end
    end

    assign o_fcs = ~crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet frame transmitter: preamble, SFD, header, payload from memory, pad, FCS, gap.
// Latency: first byte in the cycle after acceptance; payload addresses lead data by RD_LATENCY.
// Backpressure: o_ready high only in IDLE; requests are ignored while a frame or gap runs.
//
// Ports:
//   i_eth_clk, i_rst_n        : byte clock, async active-low reset
//   i_tx_start, o_ready       : request handshake (accepted when both high)
//   i_tx_size, i_dst_mac, i_src_mac, i_ethertype, i_gap_count : frame descriptor
//   o_mem_rd_addr, i_mem_rd_data : payload memory read port
//   o_tx_data, o_tx_en        : byte stream out
//   o_busy, o_frame_cnt       : status
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int MIN_IFG      = 12,
    parameter int RD_LATENCY   = 1
) (
    input  logic              i_eth_clk,
    input  logic              i_rst_n,
    input  logic              i_tx_start,
    input  logic [15:0]       i_tx_size,
    input  logic [47:0]       i_dst_mac,
    input  logic [47:0]       i_src_mac,
    input  logic [15:0]       i_ethertype,
    input  logic [7:0]        i_gap_count,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [7:0]        i_mem_rd_data,
    output logic              o_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_en,
    output logic              o_busy,
    output logic [31:0]       o_frame_cnt
);

    // Bytes before the first payload byte, and how many cycles after the
    // first preamble byte address 0 must stop being "early" and start stepping.
    localparam int HDR_LEN = PREAMBLE_LEN + 1 + 14;
    localparam int LEAD    = HDR_LEN - RD_LATENCY;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [15:0]       size_q, pad_q, gap_q;
    logic [47:0]       dst_q, src_q;
    logic [15:0]       type_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        lead_q;
    logic [31:0]       frame_cnt_q;

    logic              accept;
    logic              last_fcs;
    logic [15:0]       size_c;
    logic              crc_en, crc_init;
    logic [31:0]       fcs;
    logic [47:0]       dst_sh, src_sh;
    logic              tx_en;
    logic [7:0]        tx_data;

    assign accept   = (state_q == ST_IDLE) && i_tx_start;
    assign last_fcs = (state_q == ST_FCS) && (cnt_q == 16'd3);
    assign size_c   = (i_tx_size > 16'(MAX_PAYLOAD)) ? 16'(MAX_PAYLOAD) : i_tx_size;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Descriptor latch: frozen for the whole frame and its gap
    // ------------------------------------------------------------------
    always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            size_q <= 16'd0;
            pad_q  <= 16'd0;
            gap_q  <= 16'd0;
            dst_q  <= 48'd0;
            src_q  <= 48'd0;
            type_q <= 16'd0;
        end else if (accept) begin
            size_q <= size_c;
            pad_q  <= (size_c < 16'(MIN_PAYLOAD)) ? (16'(MIN_PAYLOAD) - size_c) : 16'd0;
            gap_q  <= 16'(MIN_IFG) + 16'(i_gap_count);
            dst_q  <= i_dst_mac;
            src_q  <= i_src_mac;
            type_q <= i_ethertype;
        end
    end

    // ------------------------------------------------------------------
    // Payload read address. Address 0 sits on the bus from acceptance;
    // after LEAD cycles it steps once per cycle so address a lands on the
    // bus exactly RD_LATENCY cycles before payload byte a goes out. It
    // stops at size-1 so nothing outside the payload is ever addressed.
    // ------------------------------------------------------------------
    always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr_q <= '0;
            lead_q    <= 8'd0;
        end else if (accept) begin
            rd_addr_q <= '0;
            lead_q    <= 8'(LEAD);
        end else if (state_q != ST_IDLE) begin
            if (lead_q != 8'd0) begin
                lead_q <= lead_q - 8'd1;
            end else if ((32'(rd_addr_q) + 32'd1) < 32'(size_q)) begin
                rd_addr_q <= rd_addr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completed-frame counter, bumps as the last FCS byte leaves
    // ------------------------------------------------------------------
    always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= 32'd0;
        end else if (last_fcs) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and byte mux. cnt_q counts bytes within the current field.
    // The gap state runs one cycle short because the IDLE cycle that
    // follows is itself an idle byte on the wire: a back-to-back request
    // then sees exactly MIN_IFG+gap_count low cycles between frames.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        crc_en  = 1'b0;
        dst_sh  = dst_q << {cnt_q[2:0], 3'b000};
        src_sh  = src_q << {cnt_q[2:0], 3'b000};

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (i_tx_start) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                tx_en   = 1'b1;
                tx_data = PREAMBLE_BYTE;
                if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_SFD;
                    cnt_d   = 16'd0;
                end
            end
            ST_SFD: begin
                tx_en   = 1'b1;
                tx_data = SFD_BYTE;
                state_d = ST_DST;
                cnt_d   = 16'd0;
            end
            ST_DST: begin
                tx_en   = 1'b1;
                tx_data = dst_sh[47:40];
                crc_en  = 1'b1;
                if (cnt_q == 16'd5) begin
                    state_d = ST_SRC;
                    cnt_d   = 16'd0;
                end
            end
            ST_SRC: begin
                tx_en   = 1'b1;
                tx_data = src_sh[47:40];
                crc_en  = 1'b1;
                if (cnt_q == 16'd5) begin
                    state_d = ST_TYPE;
                    cnt_d   = 16'd0;
                end
            end
            ST_TYPE: begin
                tx_en   = 1'b1;
                tx_data = cnt_q[0] ? type_q[7:0] : type_q[15:8];
                crc_en  = 1'b1;
                if (cnt_q == 16'd1) begin
                    cnt_d = 16'd0;
                    if (size_q != 16'd0) begin
                        state_d = ST_PAYLOAD;
                    end else if (pad_q != 16'd0) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FCS;
                    end
                end
            end
            ST_PAYLOAD: begin
                tx_en   = 1'b1;
                tx_data = i_mem_rd_data;
                crc_en  = 1'b1;
                if (cnt_q == size_q - 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = (pad_q != 16'd0) ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                tx_en   = 1'b1;
                tx_data = 8'h00;
                crc_en  = 1'b1;
                if (cnt_q == pad_q - 16'd1) begin
                    state_d = ST_FCS;
                    cnt_d   = 16'd0;
                end
            end
            ST_FCS: begin
                tx_en   = 1'b1;
                tx_data = fcs[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == 16'd3) begin
                    cnt_d   = 16'd0;
                    state_d = (gap_q > 16'd1) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == gap_q - 16'd2) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Reload in IDLE so every accepted frame starts from a fresh CRC.
    assign crc_init = (state_q == ST_IDLE);

    crc32_in8 u_crc (
        .i_clk   (i_eth_clk),
        .i_rst_n (i_rst_n),
        .i_init  (crc_init),
        .i_en    (crc_en),
        .i_data  (tx_data),
        .o_fcs   (fcs)
    );

    assign o_tx_en       = tx_en;
    assign o_tx_data     = tx_data;
    assign o_ready       = (state_q == ST_IDLE);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_mem_rd_addr = rd_addr_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
module tb_eth_tx_framer;

    localparam int ADDR_W = 16;
    localparam int PL     = 7;
    localparam int MINP   = 46;
    localparam int MAXP   = 1500;
    localparam int IFG    = 12;
    localparam int RDL    = 3;
    localparam int HDR    = PL + 1 + 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tx_start;
    logic [15:0]       tx_size;
    logic [47:0]       dst_mac, src_mac;
    logic [15:0]       etype;
    logic [7:0]        gap_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              ready;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              busy;
    logic [31:0]       frame_cnt;

    always #5 clk = ~clk;

    eth_tx_framer #(
        .ADDR_W(ADDR_W), .PREAMBLE_LEN(PL), .MIN_PAYLOAD(MINP),
        .MAX_PAYLOAD(MAXP), .MIN_IFG(IFG), .RD_LATENCY(RDL)
    ) dut (
        .i_eth_clk     (clk),
        .i_rst_n       (rst_n),
        .i_tx_start    (tx_start),
        .i_tx_size     (tx_size),
        .i_dst_mac     (dst_mac),
        .i_src_mac     (src_mac),
        .i_ethertype   (etype),
        .i_gap_count   (gap_cnt),
        .o_mem_rd_addr (rd_addr),
        .i_mem_rd_data (rd_data),
        .o_ready       (ready),
        .o_tx_data     (tx_data),
        .o_tx_en       (tx_en),
        .o_busy        (busy),
        .o_frame_cnt   (frame_cnt)
    );

    // Payload memory with an RDL-stage read pipeline.
    logic [7:0] mem  [0:65535];
    logic [7:0] pipe [0:RDL-1];
    always @(posedge clk) begin
        pipe[0] <= mem[rd_addr];
        for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
    end
    assign rd_data = pipe[RDL-1];

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    bit         en_q[$];
    int         fc_q[$];

    typedef struct {
        int size;
        int gap;
        int mode;      // 0: mem[a]=a+1, 1: random bytes
        int exp_len;
        int exp_max;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic fill_mem(input int mode);
        for (int a = 0; a < 2048; a++) mem[a] = (mode == 0) ? 8'(a + 1) : 8'($urandom);
    endtask

    // Reference frame built straight from the field list.
    task automatic build_exp(input int size, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t);
        int n;
        logic [31:0] c;
        n = (size > MAXP) ? MAXP : size;
        exp_q.delete();
        for (int i = 0; i < PL; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
        exp_q.push_back(t[15:8]);
        exp_q.push_back(t[7:0]);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
        for (int i = n; i < MINP; i++) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = PL + 1; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_and_check(input string tag, input int size, input int g,
                                  input logic [47:0] d, input logic [47:0] s,
                                  input logic [15:0] t, input int exp_len, input int exp_max);
        int guard, n, lead1, ones, mism, dz_bad, addr_bad, maxa;
        logic [31:0] fc0, res;
        n = (size > MAXP) ? MAXP : size;
        @(negedge clk);
        guard = 0;
        while (!ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " ready"}, ready, 1);
        fc0 = frame_cnt;
        tx_size = 16'(size); dst_mac = d; src_mac = s; etype = t; gap_cnt = 8'(g);
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        // Scramble the descriptor: the frame in flight must not notice.
        tx_size = 16'($urandom); dst_mac = 48'({$urandom, $urandom});
        src_mac = 48'({$urandom, $urandom}); etype = 16'($urandom); gap_cnt = 8'($urandom);
        cap_q.delete(); en_q.delete();
        dz_bad = 0; addr_bad = 0; maxa = 0; guard = 0;
        while (guard < 4000) begin
            @(negedge clk);
            if (ready) break;
            guard++;
            en_q.push_back(tx_en);
            if (tx_en) cap_q.push_back(tx_data);
            else if (tx_data != 8'h00) dz_bad++;
            if (busy) begin
                if (int'(rd_addr) > maxa) maxa = int'(rd_addr);
                if (n == 0 ? (rd_addr != 0) : (int'(rd_addr) >= n)) addr_bad++;
            end
        end
        check({tag, " finished in time"}, guard < 4000, 1);
        check({tag, " tx_en right after accept"}, (en_q.size() > 0) ? en_q[0] : 0, 1);
        lead1 = 0;
        while (lead1 < en_q.size() && en_q[lead1]) lead1++;
        ones = 0;
        foreach (en_q[i]) ones += en_q[i];
        check({tag, " tx_en run length"}, lead1, exp_len);
        check({tag, " tx_en total cycles"}, ones, exp_len);
        build_exp(size, d, s, t);
        check({tag, " byte count"}, cap_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] !== exp_q[i]) mism++;
        check({tag, " byte mismatches"}, mism, 0);
        res = 32'hFFFF_FFFF;
        for (int i = PL + 1; i < cap_q.size(); i++) res = crc_upd(res, cap_q[i]);
        check({tag, " crc residue"}, res, 32'hDEBB20E3);
        check({tag, " data zero while idle"}, dz_bad, 0);
        check({tag, " highest address"}, maxa, exp_max);
        check({tag, " out-of-range addresses"}, addr_bad, 0);
        check({tag, " frame_cnt step"}, frame_cnt, 32'(fc0 + 1));
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lead1, low, run2, idx, guard, rises, sz, n;
        bit prev;

        tbl[0] = '{0,    0, 0, 72,   0};
        tbl[1] = '{10,   0, 0, 72,   9};
        tbl[2] = '{100,  3, 1, 126,  99};
        tbl[3] = '{2000, 0, 1, 1526, 1499};
        tbl[4] = '{46,   1, 1, 72,   45};
        tbl[5] = '{45,   0, 1, 72,   44};
        tbl[6] = '{47,   2, 1, 73,   46};
        tbl[7] = '{1,    0, 1, 72,   0};

        tx_start = 0; tx_size = 0; dst_mac = 0; src_mac = 0; etype = 0; gap_cnt = 0;
        fill_mem(0);
        do_reset();
        @(negedge clk);
        check("reset ready",     ready,     1);
        check("reset busy",      busy,      0);
        check("reset tx_en",     tx_en,     0);
        check("reset tx_data",   tx_data,   0);
        check("reset rd_addr",   rd_addr,   0);
        check("reset frame_cnt", frame_cnt, 0);

        // Table-driven frames.
        for (int v = 0; v < 8; v++) begin
            fill_mem(tbl[v].mode);
            send_and_check($sformatf("vec%0d size%0d", v, tbl[v].size), tbl[v].size, tbl[v].gap,
                           48'h0011_2233_4455 + 48'(v), 48'hA0B1_C2D3_E4F5 ^ 48'(v << 8),
                           16'h0800 + 16'(v), tbl[v].exp_len, tbl[v].exp_max);
        end

        // Randomised frames against the reference model.
        for (int r = 0; r < 6; r++) begin
            sz = $urandom_range(0, 120);
            n  = sz;
            fill_mem(1);
            send_and_check($sformatf("rand%0d size%0d", r, sz), sz, $urandom_range(0, 6),
                           48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom),
                           HDR + ((n > MINP) ? n : MINP) + 4, (n > 0) ? n - 1 : 0);
        end

        // Back-to-back with start held high, gap_count = 5.
        do_reset();
        fill_mem(1);
        @(negedge clk);
        check("b2b frame_cnt initial", frame_cnt, 0);
        tx_size = 16'd20; gap_cnt = 8'd5; dst_mac = 48'h1; src_mac = 48'h2; etype = 16'h88B5;
        tx_start = 1'b1;
        en_q.delete(); fc_q.delete();
        rises = 0; prev = 0; guard = 0;
        while (guard < 1000) begin
            @(negedge clk);
            guard++;
            en_q.push_back(tx_en);
            fc_q.push_back(int'(frame_cnt));
            if (tx_en && !prev) begin
                rises++;
                if (rises == 2) tx_start = 1'b0;
            end
            prev = tx_en;
            if (rises == 2 && ready) break;
        end
        tx_start = 1'b0;
        check("b2b finished in time", guard < 1000, 1);
        lead1 = 0;
        while (lead1 < en_q.size() && en_q[lead1]) lead1++;
        low = 0;
        while (lead1 + low < en_q.size() && !en_q[lead1 + low]) low++;
        run2 = 0;
        while (lead1 + low + run2 < en_q.size() && en_q[lead1 + low + run2]) run2++;
        check("b2b first frame length", lead1, 72);
        check("b2b low cycles between frames", low, IFG + 5);
        check("b2b second frame length", run2, 72);
        check("b2b frame_cnt during frame 1", (fc_q.size() > 0) ? fc_q[0] : -1, 0);
        check("b2b frame_cnt after frame 1", (lead1 < fc_q.size()) ? fc_q[lead1] : -1, 1);
        check("b2b frame_cnt after frame 2", frame_cnt, 2);

        // Reset in the middle of the payload.
        fill_mem(0);
        send_and_check("pre-reset frame", 30, 0, 48'h5, 48'h6, 16'h0806, 72, 29);
        @(negedge clk);
        tx_size = 16'd60; gap_cnt = 8'd0; tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        idx = 0; guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (idx == HDR + 20) break;
            idx++;
        end
        check("midframe payload byte 20", tx_data, 8'(21));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midframe reset tx_en", tx_en, 0);
        check("midframe reset tx_data", tx_data, 0);
        check("midframe reset frame_cnt", frame_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset ready", ready, 1);
        check("post-reset busy", busy, 0);
        check("post-reset rd_addr", rd_addr, 0);
        fill_mem(1);
        send_and_check("after reset", 33, 2, 48'hDEAD_BEEF_0001, 48'h0200_0000_0002,
                       16'h86DD, 72, 32);
        check("after reset frame_cnt", frame_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
